mla_accumulator: RTL and testbench

//   Five-lane signed multiply-accumulate for the LWE encryptor datapath.

---
 rtl/mla_accumulator.sv | 58 +++++
 tb/tb_mla_accumulator.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mla_accumulator.sv
// Five-lane signed MAC: acc += sext(r) * zext(operand) for four row columns plus sum_val.
// Latency 1 cycle (registered outputs); no backpressure, accumulates on every non-reset edge.
module mla_accumulator #(
   parameter int DATA_WIDTH = 12,
   parameter int ACC_WIDTH  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2:0]                r,
   input  logic [4*DATA_WIDTH-1:0]   row_in,
   input  logic [DATA_WIDTH-1:0]     sum_val,
   output logic [ACC_WIDTH-1:0]      acc_col1,
   output logic [ACC_WIDTH-1:0]      acc_col2,
   output logic [ACC_WIDTH-1:0]      acc_col3,
   output logic [ACC_WIDTH-1:0]      acc_col4,
   output logic [ACC_WIDTH-1:0]      acc_sum
);

   localparam int NUM_STREAMS = 4;
   localparam int NUM_LANES   = NUM_STREAMS + 1;

   logic [DATA_WIDTH-1:0]        operand [NUM_LANES];
   logic signed [DATA_WIDTH+3:0] prod    [NUM_LANES];
   logic [ACC_WIDTH-1:0]         acc_q   [NUM_LANES];
   logic [ACC_WIDTH-1:0]         acc_d   [NUM_LANES];

   always_comb begin
      for (int k = 0; k < NUM_STREAMS; k++) begin
         operand[k] = row_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
      operand[NUM_STREAMS] = sum_val;
   end

   // Operand gets a leading 0 so 0xFFF stays +4095; the product always fits in DATA_WIDTH+3 bits.
   always_comb begin
      for (int k = 0; k < NUM_LANES; k++) begin
         prod[k]  = $signed(r) * $signed({1'b0, operand[k]});
         acc_d[k] = acc_q[k] + ACC_WIDTH'(prod[k]);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NUM_LANES; k++) begin
         if (rst) begin
            acc_q[k] <= '0;
         end else begin
            acc_q[k] <= acc_d[k];
         end
      end
   end

   assign acc_col1 = acc_q[0];
   assign acc_col2 = acc_q[1];
   assign acc_col3 = acc_q[2];
   assign acc_col4 = acc_q[3];
   assign acc_sum  = acc_q[4];

endmodule

// File: tb/tb_mla_accumulator.sv
// Scoreboard bench for mla_accumulator: per-edge expected lanes queued at drive time, popped after the edge.
module tb_mla_accumulator;

   localparam int DW = 12;
   localparam int AW = 32;

   typedef logic [4:0][AW-1:0] accs_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      r;
   logic [4*DW-1:0] row_in;
   logic [DW-1:0]   sum_val;
   logic [AW-1:0]   acc_col1, acc_col2, acc_col3, acc_col4, acc_sum;

   accs_t model_q;
   accs_t exp_q [$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   mla_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .r        (r),
      .row_in   (row_in),
      .sum_val  (sum_val),
      .acc_col1 (acc_col1),
      .acc_col2 (acc_col2),
      .acc_col3 (acc_col3),
      .acc_col4 (acc_col4),
      .acc_sum  (acc_sum)
   );

   task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one edge, queue the model's post-edge lanes, then compare after the edge.
   task automatic step(input string tag, input logic rst_v, input logic [2:0] r_v,
                       input logic [DW-1:0] c1, input logic [DW-1:0] c2,
                       input logic [DW-1:0] c3, input logic [DW-1:0] c4,
                       input logic [DW-1:0] sv);
      logic [DW-1:0] ops [5];
      int            rv;
      accs_t         got;
      accs_t         want;
      @(negedge clk);
      rst     = rst_v;
      r       = r_v;
      row_in  = {c4, c3, c2, c1};
      sum_val = sv;
      ops     = '{c1, c2, c3, c4, sv};
      rv      = r_v[2] ? int'(r_v) - 8 : int'(r_v);
      for (int k = 0; k < 5; k++) begin
         model_q[k] = rst_v ? '0 : model_q[k] + AW'(rv * int'(ops[k]));
      end
      exp_q.push_back(model_q);
      @(posedge clk);
      #1;
      got  = {acc_sum, acc_col4, acc_col3, acc_col2, acc_col1};
      want = exp_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("%s.lane%0d", tag, k), got[k], want[k]);
      end
   endtask

   task automatic chk_all(input string tag, input logic [AW-1:0] e1, input logic [AW-1:0] e2,
                          input logic [AW-1:0] e3, input logic [AW-1:0] e4,
                          input logic [AW-1:0] es);
      chk({tag, ".col1"}, acc_col1, e1);
      chk({tag, ".col2"}, acc_col2, e2);
      chk({tag, ".col3"}, acc_col3, e3);
      chk({tag, ".col4"}, acc_col4, e4);
      chk({tag, ".sum"},  acc_sum,  es);
   endtask

   task automatic do_reset();
      step("rst", 1'b1, 3'd3, 12'h111, 12'h222, 12'h333, 12'h444, 12'h555);
   endtask

   // Two-phase sequence; rst_at >= 0 pulses reset on that edge of phase one.
   task automatic run_seq(input string tag, input int rst_at);
      for (int i = 0; i < 10; i++) begin
         step(tag, i == rst_at, 3'd3, DW'(i+1), DW'(i+2), DW'(i+3), DW'(i+4), DW'(i+5));
         if (i == rst_at) chk_all({tag, ".midrst"}, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) begin
         step(tag, 1'b0, 3'b110, DW'(i+13), DW'(i+12), DW'(i+11), DW'(i+10), DW'(i+14));
      end
      step(tag, 1'b0, 3'd0, 12'hABC, 12'h123, 12'hFFF, 12'h001, 12'h777);
   endtask

   initial begin
      model_q = '0;
      rst = 1'b1; r = 3'd3; row_in = '1; sum_val = '1;

      // Reset held for two edges with live operands
      do_reset();
      chk_all("reset1", 0, 0, 0, 0, 0);
      do_reset();
      chk_all("reset2", 0, 0, 0, 0, 0);

      // Single step then hold with r=0
      step("single", 1'b0, 3'd3, 12'd1, 12'd2, 12'd3, 12'd4, 12'd5);
      chk_all("single", 3, 6, 9, 12, 15);
      step("hold", 1'b0, 3'd0, 12'hFFF, 12'h800, 12'h7FF, 12'h001, 12'hFFF);
      step("hold", 1'b0, 3'd0, 12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF);
      chk_all("hold", 3, 6, 9, 12, 15);

      // Most negative product on every lane
      do_reset();
      step("neg4", 1'b0, 3'b100, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
      chk_all("neg4", 32'hFFFFC004, 32'hFFFFC004, 32'hFFFFC004, 32'hFFFFC004, 32'hFFFFC004);

      // Wrap through zero
      do_reset();
      step("wrap", 1'b0, 3'b111, 12'd1, 12'd0, 12'd0, 12'd0, 12'd0);
      chk("wrap.down", acc_col1, 32'hFFFFFFFF);
      step("wrap", 1'b0, 3'd1, 12'd2, 12'd0, 12'd0, 12'd0, 12'd0);
      chk("wrap.up", acc_col1, 32'h00000001);

      // Full sequence
      do_reset();
      run_seq("seq", -1);
      chk_all("seq", 32'h0F, 32'h37, 32'h5F, 32'h87, 32'h7D);

      // Sequence with reset on the fifth edge; accumulation restarts from edge six
      do_reset();
      run_seq("seqrst", 4);
      chk("seqrst.col1", acc_col1, 32'hFFFFFFE2);
      chk("seqrst.col2", acc_col2, 32'hFFFFFFFB);

      // Random traffic with occasional resets
      for (int i = 0; i < 40; i++) begin
         step("rand", ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
              DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      end

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
